// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel switch debouncer.
// Each channel is polarity-adjusted and synchronised, then filtered against a
// shared sample tick. The debounced level changes only after the synchronised
// input has disagreed with it for STABLE consecutive ticks. Registered rise and
// fall strobes mark each change of the debounced level.
module debounce_bank #(
  parameter int          CH         = 4,
  parameter int          N          = 19,
  parameter int          STABLE     = 3,
  parameter logic [CH-1:0] ACTIVE_LOW = {CH{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          tick
);

  // Stability counter width; at least one bit even when STABLE is 1.
  localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
  // Count value at which the next tick completes the waiting chain.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  logic [CH-1:0]         p_s;
  logic                  tick_s;

  logic [N-1:0]          q_q,    q_d;
  logic [CH-1:0]         s1_q,   s1_d;
  logic [CH-1:0]         s_q,    s_d;
  logic [CH-1:0]         db_q,   db_d;
  logic [CH-1:0]         rise_q, rise_d;
  logic [CH-1:0]         fall_q, fall_d;
  logic [CH-1:0][CW-1:0] cnt_q,  cnt_d;

  // Input polarity: active-low channels are inverted before synchronisation.
  assign p_s = sw ^ ACTIVE_LOW;

  // Shared sample tick: one cycle in every 2^N, when the free-running counter is all ones.
  assign tick_s = (q_q == {N{1'b1}});

  // Next-state logic: tick counter, synchroniser shift and per-channel filter.
  always_comb begin
    q_d    = q_q + N'(1'b1);
    s1_d   = p_s;
    s_d    = s1_q;
    db_d   = db_q;
    rise_d = {CH{1'b0}};
    fall_d = {CH{1'b0}};
    cnt_d  = cnt_q;
    for (int i = 0; i < CH; i++) begin
      if (s_q[i] == db_q[i]) begin
        // Input agrees (or bounced back): any pending change is cancelled.
        cnt_d[i] = {CW{1'b0}};
      end else if (tick_s && (cnt_q[i] == CNT_LAST)) begin
        // Chain complete: flip the level and strobe the matching edge.
        db_d[i]   = ~db_q[i];
        cnt_d[i]  = {CW{1'b0}};
        rise_d[i] = ~db_q[i];
        fall_d[i] = db_q[i];
      end else if (tick_s) begin
        cnt_d[i] = cnt_q[i] + CW'(1'b1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= {N{1'b0}};
      s1_q   <= {CH{1'b0}};
      s_q    <= {CH{1'b0}};
      db_q   <= {CH{1'b0}};
      rise_q <= {CH{1'b0}};
      fall_q <= {CH{1'b0}};
      cnt_q  <= {(CH*CW){1'b0}};
    end else begin
      q_q    <= q_d;
      s1_q   <= s1_d;
      s_q    <= s_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign tick = tick_s;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed bench for debounce_bank with CH=4, N=3, STABLE=3,
// ACTIVE_LOW=4'b1000.
// Time reference: n counts rising edges with reset low since the last release.
// After n such edges the tick counter holds n mod 8, so tick is high whenever
// n mod 8 == 7. An input applied at n reaches the filter at n+2, and a level
// change lands on the edge after the third tick seen by the filter.
module tb_debounce_bank;

  logic       clk;
  logic       reset;
  logic [3:0] sw;
  logic [3:0] db;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       tick;

  int checks;
  int failures;
  int n;
  logic [3:0] strobe_seen;

  debounce_bank #(
    .CH        (4),
    .N         (3),
    .STABLE    (3),
    .ACTIVE_LOW(4'b1000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw),
    .db   (db),
    .rise (rise),
    .fall (fall),
    .tick (tick)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (n=%0d)", tag, obs, exp, n);
    end
  endtask

  // Advance to edge count 'target', sampling 1 ns after each edge; records any strobe seen.
  task automatic run_to(input int target);
    while (n < target) begin
      @(posedge clk);
      #1;
      n++;
      strobe_seen = strobe_seen | rise | fall;
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    n           = 0;
    strobe_seen = 4'b0000;
    reset       = 1'b1;
    sw          = 4'b0000;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_db",   db,   4'b0000);
    check_eq("rst_rise", rise, 4'b0000);
    check_eq("rst_fall", fall, 4'b0000);
    check_eq("rst_tick", {3'b000, tick}, 4'b0000);

    // Clean press on ch0; ch3 is active-low with sw[3]=0 so it also goes high.
    reset = 1'b0;
    sw    = 4'b0001;
    n     = 0;
    run_to(6);
    check_eq("tick_n6", {3'b000, tick}, 4'b0000);
    run_to(7);
    check_eq("tick_n7", {3'b000, tick}, 4'b0001);
    run_to(8);
    check_eq("tick_wrap", {3'b000, tick}, 4'b0000);
    run_to(23);
    check_eq("press_db_before", db, 4'b0000);
    check_eq("press_tick", {3'b000, tick}, 4'b0001);
    run_to(24);
    check_eq("press_db",   db,   4'b1001);
    check_eq("press_rise", rise, 4'b1001);
    check_eq("press_fall", fall, 4'b0000);
    run_to(25);
    check_eq("press_rise_end", rise, 4'b0000);
    check_eq("press_db_hold",  db,   4'b1001);

    // Bounce on ch1: 5 cycles high / 5 low, never spanning two ticks.
    strobe_seen = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      sw[1] = (k % 2 == 0);
      run_to(n + 5);
      check_eq("bounce_db1", {3'b000, db[1]}, 4'b0000);
    end
    check_eq("bounce_strobes", strobe_seen, 4'b0000);
    // Settle high at n=65: filter sees it at 67, ticks at 71/79/87, change at 88.
    sw[1] = 1'b1;
    run_to(87);
    check_eq("settle_db_before", {3'b000, db[1]}, 4'b0000);
    run_to(88);
    check_eq("settle_db",   db,   4'b1011);
    check_eq("settle_rise", rise, 4'b0010);
    check_eq("settle_fall", fall, 4'b0000);
    run_to(89);
    check_eq("settle_rise_end", rise, 4'b0000);

    // Release ch0 at n=89: filter sees it at 91, ticks 95/103/111, change at 112.
    sw = 4'b0010;
    run_to(111);
    check_eq("release_db_before", db, 4'b1011);
    run_to(112);
    check_eq("release_db",   db,   4'b1010);
    check_eq("release_fall", fall, 4'b0001);
    check_eq("release_rise", rise, 4'b0000);
    run_to(113);
    check_eq("release_fall_end", fall, 4'b0000);

    // Ch2 goes high at 113 (filter at 115, cnt=2 after tick 127); it drops
    // back at 133 so the filter sees the return exactly on tick cycle 135.
    sw = 4'b0110;
    run_to(133);
    sw = 4'b0010;
    run_to(135);
    check_eq("mis_tick", {3'b000, tick}, 4'b0001);
    check_eq("mis_db_on_tick", db, 4'b1010);
    run_to(136);
    check_eq("mis_db_after", db,   4'b1010);
    check_eq("mis_rise",     rise, 4'b0000);
    // Fresh chain from a cleared count: filter at 138, ticks 143/151/159, change at 160.
    sw = 4'b0110;
    run_to(144);
    check_eq("mis_no_early", db, 4'b1010);
    run_to(159);
    check_eq("mis_db_before", db, 4'b1010);
    run_to(160);
    check_eq("mis_db",   db,   4'b1110);
    check_eq("mis_rise2", rise, 4'b0100);

    // Pending changes on ch0/1/2 (cnt=2 after tick 175), then reset at edge 178.
    sw = 4'b0001;
    run_to(177);
    check_eq("midrst_pending_db", db, 4'b1110);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_db",   db,   4'b0000);
    check_eq("midrst_rise", rise, 4'b0000);
    check_eq("midrst_fall", fall, 4'b0000);
    check_eq("midrst_tick", {3'b000, tick}, 4'b0000);

    // Release with ch0 and ch1 high and ch3 held inactive (sw[3]=1).
    reset = 1'b0;
    sw    = 4'b1011;
    n     = 0;
    run_to(23);
    check_eq("restart_db_before", db, 4'b0000);
    run_to(24);
    check_eq("restart_db",   db,   4'b0011);
    check_eq("restart_rise", rise, 4'b0011);
    check_eq("restart_fall", fall, 4'b0000);
    run_to(25);
    check_eq("restart_rise_end", rise, 4'b0000);

    // Parallel fall of ch0/ch1 at 25 (filter 27, ticks 31/39/47, change 48).
    sw = 4'b1000;
    run_to(47);
    check_eq("par_fall_db_before", db, 4'b0011);
    run_to(48);
    check_eq("par_fall_db",   db,   4'b0000);
    check_eq("par_fall_fall", fall, 4'b0011);
    check_eq("par_fall_rise", rise, 4'b0000);
    // Parallel rise driven on the same cycle, n=48 (filter 50, ticks 55/63/71, change 72).
    sw = 4'b1011;
    run_to(71);
    check_eq("par_rise_db_before", db, 4'b0000);
    run_to(72);
    check_eq("par_rise_db",   db,   4'b0011);
    check_eq("par_rise_rise", rise, 4'b0011);
    check_eq("par_rise_fall", fall, 4'b0000);
    run_to(73);
    check_eq("par_rise_end", rise, 4'b0000);
    check_eq("par_db_hold",  db,   4'b0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
